// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the core load/store path and the
// external loader port. Optional stall-cycle counter is enabled by DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t            state;
  owner_t            owner;
  logic [3:0]        burst_cnt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              grant_ext;
  logic              in_access;

  // The external port wins when the CPU is idle or has used up its burst.
  assign grant_ext = ext_req & (~cpu_req | (burst_cnt == BURST_MAX));

  always_ff @(posedge clock) begin
    // NOTE: every state register uses non-blocking assignment so all flops
    // update from the same pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      burst_cnt <= '0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ext_req) begin
            state    <= ACCESS;
            wait_cnt <= WAIT_INIT;
            if (grant_ext) begin
              owner     <= OWN_EXT;
              addr_q    <= ext_addr;
              wdata_q   <= ext_wdata;
              we_q      <= ext_we;
              burst_cnt <= '0;
            end else begin
              owner   <= OWN_CPU;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
              we_q    <= cpu_we;
              if (ext_req)
                burst_cnt <= (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
              else
                burst_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state <= DONE;
            // Writes leave the owner's rdata untouched.
            if (owner == OWN_EXT) begin
              ext_ack <= 1'b1;
              if (!we_q) ext_rdata <= mem_read_data;
            end else begin
              cpu_ack <= 1'b1;
              if (!we_q) cpu_rdata <= mem_read_data;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          ext_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode only flop outputs, so there is no input-to-memory path.
  assign in_access       = (state == ACCESS);
  assign busy            = (state != IDLE);
  assign mem_access_addr = in_access ? addr_q  : '0;
  assign mem_write_data  = in_access ? wdata_q : '0;
  assign mem_read        = in_access & ~we_q;
  assign mem_write_en    = in_access & we_q & (wait_cnt == WAIT_INIT);
  assign cpu_stall       = cpu_req & ~cpu_ack;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset)
      stall_cycles <= '0;
    else if (cpu_stall && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data_memory port between two requesters:
  - the core's load/store path;
  - an external port used by the debug/program loader.
- Owns the mem_* strobes to data_memory and stalls the core (freezes the PC update) while a core access is pending.
- Fixed CPU priority, with a burst limit so the external port cannot starve.

Parameters:
- ADDR_W, 16, address width (matches ALU result width)
- DATA_W, 16, data width
- WAIT_CYCLES, 1, cycles in ACCESS state per transaction; legal range 1..15
- MAX_BURST, 4, consecutive CPU grants allowed while ext_req is pending; legal range 1..15

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  core requests an access; held until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data; valid while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- ext_req  in  1  external requests an access; held until ext_ack
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  ADDR_W  access address
- ext_wdata  in  DATA_W  write data
- ext_rdata  out  DATA_W  read data; valid while ext_ack = 1
- ext_ack  out  1  one-cycle completion pulse
- mem_access_addr  out  ADDR_W  to data_memory
- mem_write_data  out  DATA_W  to data_memory
- mem_write_en  out  1  to data_memory
- mem_read  out  1  to data_memory
- mem_read_data  in  DATA_W  from data_memory
- busy  out  1  1 when state is not IDLE
- stall_cycles  out  16  CPU stall-cycle counter (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; owner = CPU; burst_cnt = 0; wait_cnt = 0; latched addr/data/we = 0.
- Reset applied mid-transaction: IDLE on the next edge; mem_write_en and both acks are 0 from that edge. The aborted access is not acked.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- No request: stay in IDLE.
- Any request: choose owner, then go to ACCESS.
  - Owner = EXT if ext_req & (~cpu_req | burst_cnt == MAX_BURST); otherwise CPU.
- On the transition, latch owner, addr, wdata, we; set wait_cnt = WAIT_CYCLES - 1.
- burst_cnt update:
  - +1 when CPU is granted while ext_req = 1;
  - cleared when EXT is granted, or when CPU is granted with ext_req = 0;
  - saturates at MAX_BURST.

ACCESS:
- mem_access_addr and mem_write_data driven from the latches.
- mem_read = ~we for every ACCESS cycle.
- mem_write_en = we only in the first ACCESS cycle, so exactly one write per transaction.
- wait_cnt decrements each cycle; when wait_cnt == 0, capture mem_read_data into the owner's rdata register and go to DONE.

DONE:
- Pulse the owner's ack for exactly one cycle; rdata holds the captured value.
- On a write, rdata holds its previous value.
- Always return to IDLE; no back-to-back grant without passing through IDLE.

Timing and handshake:
- Uncontended latency: request sampled at edge N, ack high in cycle N + WAIT_CYCLES + 1. With the default this is 3 cycles per access.
- Requester holds req and its payload stable until ack and drops req in the ack cycle. If req is still high in IDLE after DONE, it is a new request.
- Payload changes after the grant edge are ignored (latched copy is used).
- Request withdrawn mid-transaction: the transaction completes and the ack is still pulsed.
- Simultaneous cpu_req and ext_req with burst_cnt < MAX_BURST: CPU wins; ext waits with its ack low.
- mem_* outputs are 0 in IDLE and DONE.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - stall_cycles increments every cycle with cpu_stall = 1; saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined:
  - No counter logic; stall_cycles is tied to 16'd0.
  - All other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy = 0.
- CPU store addr 16'h0010, data 16'hBEEF, then CPU load addr 16'h0010 -> exactly one mem_write_en cycle; load ack 3 cycles after its request; cpu_rdata = 16'hBEEF; cpu_stall high for 2 cycles per access.
- cpu_req and ext_req asserted together and held, MAX_BURST = 4 -> grant order CPU, CPU, CPU, CPU, EXT, CPU ...; ext_ack occurs after the 4th cpu_ack.
- Ext write addr 16'h0020, data 16'h1234, then CPU load 16'h0020 -> cpu_rdata = 16'h1234.
- WAIT_CYCLES = 3, CPU load in progress, reset asserted in the 2nd ACCESS cycle -> next cycle IDLE, cpu_ack never pulses, mem_read = 0.
- DMEM_ARB_PERF_EN defined, 10 uncontended CPU loads -> stall_cycles = 20.
- DMEM_ARB_PERF_EN undefined, same stimulus -> stall_cycles = 0.
